// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state codes, opcodes,
// fault codes, completion indices and the decoded-control bundle.
package control_sequencer_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_INIT   = 4'd0;
  localparam state_t ST_IDLE   = 4'd1;
  localparam state_t ST_FETCH  = 4'd2;
  localparam state_t ST_DECODE = 4'd3;
  localparam state_t ST_EXEC   = 4'd4;
  localparam state_t ST_MEM    = 4'd5;
  localparam state_t ST_WB     = 4'd6;
  localparam state_t ST_BRANCH = 4'd7;
  localparam state_t ST_JUMP   = 4'd8;
  localparam state_t ST_HALT   = 4'd9;
  localparam state_t ST_FAULT  = 4'd10;

  localparam logic [3:0] OP_LW   = 4'b0000;
  localparam logic [3:0] OP_SW   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BNE  = 4'b1100;
  localparam logic [3:0] OP_JMP  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // Bit positions of the completion inputs inside the packed history vector.
  localparam int EV_READ   = 0;
  localparam int EV_DECODE = 1;
  localparam int EV_EXEC   = 2;
  localparam int EV_MEM    = 3;
  localparam int EV_WB     = 4;
  localparam int EV_PC     = 5;

  typedef struct packed {
    logic       alu_mode;
    logic [2:0] op;
    logic       mem_read;
    logic       mem_write;
    logic       write_back;
    logic       is_branch;
    logic       is_jump;
    logic       is_halt;
    logic       illegal;
  } ctl_t;

  function automatic logic is_wait_state(input state_t s);
    return s inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_BRANCH, ST_JUMP};
  endfunction

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// Combinational opcode decode; the sequencer latches the result when it
// leaves DECODE.
module opcode_decoder
  import control_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output ctl_t       ctl
);

  always_comb begin
    ctl = '0;
    case (opcode)
      OP_LW: begin
        ctl.mem_read   = 1'b1;
        ctl.write_back = 1'b1;
      end
      OP_SW: ctl.mem_write = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT: begin
        // ALU ops are numbered from 2, so op is the low bits of opcode-2.
        ctl.alu_mode   = 1'b1;
        ctl.op         = opcode[2:0] - 3'd2;
        ctl.write_back = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctl.op        = 3'b001;
        ctl.is_branch = 1'b1;
      end
      OP_JMP:  ctl.is_jump = 1'b1;
      OP_HALT: ctl.is_halt = 1'b1;
      default: ctl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM for the 16-bit RISC datapath: phase requests,
// latched per-instruction controls, retired count, illegal/timeout traps.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             readInstructionComplete,
  input  logic             decodeComplete,
  input  logic             executeComplete,
  input  logic             memoryOperationComplete,
  input  logic             writeBackComplete,
  input  logic             pcSetForBranch,
  output logic             readInstruction,
  output logic             execute,
  output logic             jumpExecute,
  output logic             memRead,
  output logic             memWrite,
  output logic             writeBack,
  output logic             aluMode,
  output logic [2:0]       op,
  output logic             resetInstructionMemory,
  output logic             resetALU,
  output logic             resetDataMemory,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       faultCode,
  output logic [CNT_W-1:0] instrCount,
  output logic [3:0]       state_dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_n;
  logic [5:0]    cmp_in, cmp_q, cmp_ev;
  logic [TW-1:0] tmr;
  logic          tmo;
  logic [1:0]    fault_code_n;
  logic          branch_q;
  logic          latch_ctl, clear_ctl, retire;
  ctl_t          dec;

  opcode_decoder u_dec (
    .opcode (opcode),
    .ctl    (dec)
  );

  // Handshake: a request strobe stays high while its state waits; the
  // datapath answers with a completion level, and only its rising edge
  // (in & ~in_q) advances the FSM, so a level left high never re-fires.
  assign cmp_in = {pcSetForBranch, writeBackComplete, memoryOperationComplete,
                   executeComplete, decodeComplete, readInstructionComplete};
  assign cmp_ev = cmp_in & ~cmp_q;
  assign tmo    = (tmr >= TW'(TIMEOUT - 1));
  assign state_dbg = state;

  always_comb begin
    state_n      = state;
    fault_code_n = FC_NONE;
    case (state)
      ST_INIT:          state_n = ST_IDLE;
      ST_IDLE, ST_HALT: if (start) state_n = ST_FETCH;
      ST_FETCH:         if (cmp_ev[EV_READ]) state_n = ST_DECODE;
      ST_DECODE: begin
        if (cmp_ev[EV_DECODE]) begin
          if (dec.illegal) begin
            state_n      = ST_FAULT;
            fault_code_n = FC_ILLEGAL;
          end else if (dec.is_jump) state_n = ST_JUMP;
          else if (dec.is_halt)     state_n = ST_HALT;
          else                      state_n = ST_EXEC;
        end
      end
      ST_EXEC:   if (cmp_ev[EV_EXEC]) state_n = branch_q ? ST_BRANCH : ST_MEM;
      ST_MEM:    if (cmp_ev[EV_MEM])  state_n = ST_WB;
      ST_BRANCH: if (cmp_ev[EV_PC])   state_n = ST_WB;
      ST_JUMP:   if (cmp_ev[EV_PC])   state_n = ST_WB;
      ST_WB:     if (cmp_ev[EV_WB])   state_n = ST_FETCH;
      ST_FAULT:  state_n = ST_FAULT;
      default:   state_n = ST_INIT;
    endcase
    // A completion seen in the same cycle as the timeout wins.
    if (is_wait_state(state) && state_n == state && tmo) begin
      state_n      = ST_FAULT;
      fault_code_n = FC_TIMEOUT;
    end
  end

  assign latch_ctl = (state == ST_DECODE) && (state_n != ST_DECODE) && (state_n != ST_FAULT);
  assign clear_ctl = ((state == ST_WB) && (state_n != ST_WB)) || (state_n == ST_FAULT);
  assign retire    = ((state == ST_WB) && (state_n == ST_FETCH)) ||
                     ((state != ST_HALT) && (state_n == ST_HALT));

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state                  <= ST_INIT;
      cmp_q                  <= '0;
      tmr                    <= '0;
      readInstruction        <= 1'b0;
      execute                <= 1'b0;
      jumpExecute            <= 1'b0;
      aluMode                <= 1'b0;
      op                     <= '0;
      memRead                <= 1'b0;
      memWrite               <= 1'b0;
      writeBack              <= 1'b0;
      branch_q               <= 1'b0;
      resetInstructionMemory <= 1'b1;
      resetALU               <= 1'b1;
      resetDataMemory        <= 1'b1;
      busy                   <= 1'b0;
      halted                 <= 1'b0;
      fault                  <= 1'b0;
      faultCode              <= FC_NONE;
      instrCount             <= '0;
    end else begin
      state <= state_n;
      cmp_q <= cmp_in;
      if (state_n != state)      tmr <= '0;
      else if (tmr != TW'(TIMEOUT)) tmr <= tmr + 1'b1;

      readInstruction        <= (state_n == ST_FETCH);
      execute                <= (state_n == ST_EXEC);
      jumpExecute            <= (state_n == ST_JUMP);
      busy                   <= is_wait_state(state_n);
      halted                 <= (state_n == ST_HALT);
      fault                  <= (state_n == ST_FAULT);
      resetInstructionMemory <= (state_n == ST_INIT);
      resetALU               <= (state_n == ST_INIT);
      resetDataMemory        <= (state_n == ST_INIT);

      if (latch_ctl) begin
        aluMode   <= dec.alu_mode;
        op        <= dec.op;
        memRead   <= dec.mem_read;
        memWrite  <= dec.mem_write;
        writeBack <= dec.write_back;
        branch_q  <= dec.is_branch;
      end else if (clear_ctl) begin
        aluMode   <= 1'b0;
        op        <= '0;
        memRead   <= 1'b0;
        memWrite  <= 1'b0;
        writeBack <= 1'b0;
        branch_q  <= 1'b0;
      end

      if ((state_n == ST_FAULT) && (state != ST_FAULT)) faultCode <= fault_code_n;
      if (retire) instrCount <= instrCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: the bench plays the datapath,
// raising each completion a fixed number of cycles into a phase.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic [5:0]  cmp = 6'd0;
  logic        readInstruction, execute, jumpExecute;
  logic        memRead, memWrite, writeBack, aluMode;
  logic [2:0]  op;
  logic        resetInstructionMemory, resetALU, resetDataMemory;
  logic        busy, halted, fault;
  logic [1:0]  faultCode;
  logic [15:0] instrCount;
  logic [3:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int jmp_hi   = 0;
  int ex_hi    = 0;
  int t0, jb, eb, n;
  logic [15:0] exp_q[$];

  control_sequencer #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk                     (clk),
    .resetN                  (resetN),
    .start                   (start),
    .opcode                  (opcode),
    .readInstructionComplete (cmp[0]),
    .decodeComplete          (cmp[1]),
    .executeComplete         (cmp[2]),
    .memoryOperationComplete (cmp[3]),
    .writeBackComplete       (cmp[4]),
    .pcSetForBranch          (cmp[5]),
    .readInstruction         (readInstruction),
    .execute                 (execute),
    .jumpExecute             (jumpExecute),
    .memRead                 (memRead),
    .memWrite                (memWrite),
    .writeBack               (writeBack),
    .aluMode                 (aluMode),
    .op                      (op),
    .resetInstructionMemory  (resetInstructionMemory),
    .resetALU                (resetALU),
    .resetDataMemory         (resetDataMemory),
    .busy                    (busy),
    .halted                  (halted),
    .fault                   (fault),
    .faultCode               (faultCode),
    .instrCount              (instrCount),
    .state_dbg               (state_dbg)
  );

  // clock / cycle bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (jumpExecute) jmp_hi++;
    if (execute) ex_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver: one reset pulse, checking the reset and INIT values
  task automatic do_reset(input string tag);
    cmp    = 6'd0;
    start  = 1'b0;
    resetN = 1'b0;
    @(negedge clk);
    check({tag, ".state"}, state_dbg, ST_INIT);
    check({tag, ".subresets"}, {resetInstructionMemory, resetALU, resetDataMemory}, 3'b111);
    check({tag, ".outs"}, {readInstruction, execute, jumpExecute, memRead, memWrite,
                           writeBack, aluMode, op, busy, halted, fault, faultCode}, 0);
    check({tag, ".count"}, instrCount, 0);
    resetN = 1'b1;
    @(negedge clk);
    check({tag, ".idle"}, state_dbg, ST_IDLE);
    check({tag, ".subresets_off"}, {resetInstructionMemory, resetALU, resetDataMemory}, 3'b000);
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // driver: one datapath phase; completion rises after lat cycles, drops a cycle later
  task automatic phase(input string tag, input state_t st, input int idx, input int lat);
    check({tag, ".state"}, state_dbg, st);
    repeat (lat) @(negedge clk);
    cmp[idx] = 1'b1;
    @(negedge clk);
    cmp[idx] = 1'b0;
  endtask

  // ALU / LW / SW: exp_ctl = {aluMode, op, memRead, memWrite, writeBack}
  task automatic run_instr(input string tag, input logic [3:0] opc, input logic [6:0] exp_ctl);
    opcode = opc;
    phase({tag, ".f"}, ST_FETCH, 0, 1);
    check({tag, ".fetch_drop"}, readInstruction, 1'b0);
    phase({tag, ".d"}, ST_DECODE, 1, 1);
    check({tag, ".ctl"}, {aluMode, op, memRead, memWrite, writeBack}, exp_ctl);
    check({tag, ".execute"}, execute, 1'b1);
    phase({tag, ".e"}, ST_EXEC, 2, 1);
    phase({tag, ".m"}, ST_MEM, 3, 1);
    check({tag, ".ctl_held"}, {aluMode, op, memRead, memWrite, writeBack}, exp_ctl);
    phase({tag, ".w"}, ST_WB, 4, 1);
    check({tag, ".count"}, instrCount, exp_q.pop_front());
    check({tag, ".ctl_clear"}, {aluMode, op, memRead, memWrite, writeBack}, 7'd0);
  endtask

  initial begin
    do_reset("rst0");

    // ADD: retires 10 cycles after start is sampled
    opcode = OP_ADD;
    start  = 1'b1;
    t0     = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check("alu.req", {readInstruction, busy}, 2'b11);
    exp_q.push_back(16'd1);
    run_instr("alu", OP_ADD, 7'b1_000_001);
    check("alu.latency", cyc - t0, 10);

    exp_q.push_back(16'd2);
    run_instr("lw", OP_LW, 7'b0_000_101);
    exp_q.push_back(16'd3);
    run_instr("sw", OP_SW, 7'b0_000_010);
    exp_q.push_back(16'd4);
    run_instr("or", OP_OR, 7'b1_011_001);
    exp_q.push_back(16'd5);
    run_instr("slt", OP_SLT, 7'b1_111_001);

    // JMP: pcSetForBranch in the third cycle of jumpExecute
    opcode = OP_JMP;
    jb = jmp_hi;
    eb = ex_hi;
    phase("jmp.f", ST_FETCH, 0, 1);
    phase("jmp.d", ST_DECODE, 1, 1);
    check("jmp.req", {jumpExecute, execute, busy}, 3'b101);
    phase("jmp.j", ST_JUMP, 5, 2);
    check("jmp.held", jmp_hi - jb, 3);
    check("jmp.no_exec", ex_hi - eb, 0);
    phase("jmp.w", ST_WB, 4, 1);
    check("jmp.count", instrCount, 16'd6);

    // BNE goes EXEC -> BRANCH -> WB
    opcode = OP_BNE;
    phase("bne.f", ST_FETCH, 0, 1);
    phase("bne.d", ST_DECODE, 1, 1);
    check("bne.ctl", {aluMode, op, writeBack}, 5'b0_001_0);
    phase("bne.e", ST_EXEC, 2, 1);
    phase("bne.b", ST_BRANCH, 5, 1);
    phase("bne.w", ST_WB, 4, 1);
    check("bne.count", instrCount, 16'd7);

    // decodeComplete left high across instructions
    opcode = OP_ADD;
    phase("hold.f", ST_FETCH, 0, 1);
    @(negedge clk);
    cmp[1] = 1'b1;
    @(negedge clk);
    phase("hold.e", ST_EXEC, 2, 1);
    phase("hold.m", ST_MEM, 3, 1);
    phase("hold.w", ST_WB, 4, 1);
    phase("hold.f2", ST_FETCH, 0, 1);
    repeat (2) @(negedge clk);
    check("hold.no_retrigger", state_dbg, ST_DECODE);
    cmp[1] = 1'b0;
    @(negedge clk);
    cmp[1] = 1'b1;
    @(negedge clk);
    check("hold.fresh_edge", state_dbg, ST_EXEC);
    cmp[1] = 1'b0;
    phase("hold.e2", ST_EXEC, 2, 1);
    check("hold.in_mem", {state_dbg, instrCount}, {ST_MEM, 16'd8});

    // reset in the middle of MEM
    do_reset("rst_mid");

    // HALT counts on entry, start resumes
    opcode = OP_HALT;
    kick();
    phase("halt.f", ST_FETCH, 0, 1);
    phase("halt.d", ST_DECODE, 1, 1);
    check("halt.state", state_dbg, ST_HALT);
    check("halt.status", {halted, busy, fault}, 3'b100);
    check("halt.count", instrCount, 16'd1);
    kick();
    check("halt.resume", {state_dbg, halted, readInstruction}, {ST_FETCH, 1'b0, 1'b1});

    // executeComplete never comes: 8 cycles in EXEC then timeout fault
    opcode = OP_ADD;
    phase("tmo.f", ST_FETCH, 0, 1);
    phase("tmo.d", ST_DECODE, 1, 1);
    n = 0;
    while (state_dbg == ST_EXEC && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("tmo.cycles", n, 8);
    check("tmo.state", state_dbg, ST_FAULT);
    check("tmo.status", {fault, faultCode, execute, busy, writeBack, aluMode}, 7'b1_10_0000);

    do_reset("rst_tmo");

    // illegal opcode 1010 traps; start ignored in FAULT
    opcode = 4'b1010;
    kick();
    phase("ill.f", ST_FETCH, 0, 1);
    phase("ill.d", ST_DECODE, 1, 1);
    check("ill.status", {state_dbg, fault, faultCode, readInstruction}, {ST_FAULT, 1'b1, 2'b01, 1'b0});
    kick();
    repeat (2) @(negedge clk);
    check("ill.sticky", {state_dbg, readInstruction, busy}, {ST_FAULT, 2'b00});
    do_reset("rst_ill");

    // illegal opcode 1110 as well
    opcode = 4'b1110;
    kick();
    phase("ill2.f", ST_FETCH, 0, 1);
    phase("ill2.d", ST_DECODE, 1, 1);
    check("ill2.status", {fault, faultCode, instrCount}, {1'b1, 2'b01, 16'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
